// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-masked data memory with valid/ready request and response channels.
// Define DMEM_PRELOAD_EN to load a boot table into words 0..10 after the clear sweep.
module dmem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [IW-1:0] LAST = IW'(MEM_SIZE - 1);

`ifdef DMEM_PRELOAD_EN
    typedef enum logic [1:0] {CLEAR, PRELOAD, READY} state_t;

    function automatic logic [3:0] boot_word(input logic [3:0] i);
        case (i)
            4'd0:    boot_word = 4'd1;
            4'd1:    boot_word = 4'd6;
            4'd2:    boot_word = 4'd10;
            4'd3:    boot_word = 4'd11;
            4'd4:    boot_word = 4'd14;
            4'd5:    boot_word = 4'd4;
            4'd6:    boot_word = 4'd8;
            4'd7:    boot_word = 4'd0;
            4'd8:    boot_word = 4'd1;
            4'd9:    boot_word = 4'd3;
            4'd10:   boot_word = 4'd5;
            default: boot_word = 4'd0;
        endcase
    endfunction

    logic [3:0] pre_q, pre_d;
`else
    typedef enum logic [1:0] {CLEAR, READY} state_t;
`endif

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  in_range;
    logic [IW-1:0]         req_idx;
    logic                  accept;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_be;

    assign in_range = {1'b0, req_addr} < SIZE_W;
    assign req_idx  = req_addr[IW-1:0];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_PRELOAD_EN
        pre_d       = pre_q;
`endif
        busy        = 1'b1;
        req_ready   = 1'b0;
        accept      = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_q;
        wr_data     = '0;
        wr_be       = '1;
        unique case (state_q)
            CLEAR: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    ptr_d   = '0;
`ifdef DMEM_PRELOAD_EN
                    state_d = PRELOAD;
`else
                    state_d = READY;
`endif
                end
            end
`ifdef DMEM_PRELOAD_EN
            PRELOAD: begin
                wr_en   = int'(pre_q) < MEM_SIZE;
                wr_idx  = IW'(pre_q);
                wr_data = DATA_WIDTH'(boot_word(pre_q));
                pre_d   = pre_q + 4'd1;
                if (pre_q == 4'd10) begin
                    pre_d   = '0;
                    state_d = READY;
                end
            end
`endif
            READY: begin
                busy      = 1'b0;
                req_ready = !rsp_valid_q || rsp_ready;
                accept    = req_valid && req_ready;
                if (rsp_ready) rsp_valid_d = 1'b0;
                if (accept && req_write) begin
                    // out-of-range writes are accepted but dropped
                    wr_en   = in_range;
                    wr_idx  = req_idx;
                    wr_data = req_wdata;
                    wr_be   = req_wmask;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !in_range;
                    rsp_rdata_d = in_range ? mem[req_idx] : '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_PRELOAD_EN
            pre_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_PRELOAD_EN
            pre_q       <= pre_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
